p_hit_pipe: RTL and testbench

P_HIT_PIPE -- requirements
Module: p_hit_pipe

---
 rtl/p_hit_pipe_if.sv | 28 ++
 rtl/p_hit_pipe.sv | 174 +++++++++++++++++
 tb/tb_p_hit_pipe.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/p_hit_pipe_if.sv
// Ray/triangle hit pipeline port bundle: upstream FIFO read side plus result
// FIFO-style output side. The slave modport is the pipeline, master is its environment.
interface p_hit_pipe_if #(
    parameter int DATA_WIDTH = 32
);
    logic signed [DATA_WIDTH-1:0] tri_normal [2:0];
    logic signed [DATA_WIDTH-1:0] v0         [2:0];
    logic signed [DATA_WIDTH-1:0] origin     [2:0];
    logic signed [DATA_WIDTH-1:0] dir        [2:0];
    logic                         in_empty;
    logic                         in_rd_en;

    logic signed [DATA_WIDTH-1:0] out        [2:0];
    logic signed [DATA_WIDTH-1:0] out_t;
    logic                         out_hit;
    logic                         out_empty;
    logic                         out_rd_en;

    modport master (
        output tri_normal, v0, origin, dir, in_empty, out_rd_en,
        input  in_rd_en, out, out_t, out_hit, out_empty
    );

    modport slave (
        input  tri_normal, v0, origin, dir, in_empty, out_rd_en,
        output in_rd_en, out, out_t, out_hit, out_empty
    );
endinterface

// File: rtl/p_hit_pipe.sv
// Fixed-point ray/plane intersection: t = n.(v0-o) / n.dir, hit point = o + t*dir.
// Define P_HIT_CULL_EN to treat back faces (n.dir >= 0) as misses.
module p_hit_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int Q_BITS     = 16
) (
    input  logic        clock,
    input  logic        reset,
    p_hit_pipe_if.slave bus
);
    localparam int DIV_CYCLES = DATA_WIDTH + Q_BITS;
    localparam int CNT_W      = $clog2(DIV_CYCLES + 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DOT   = 3'd1;
    localparam logic [2:0] DIV   = 3'd2;
    localparam logic [2:0] SCALE = 3'd3;
    localparam logic [2:0] ADD   = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]                   state;
    logic signed [DATA_WIDTH-1:0] n_r      [3];
    logic signed [DATA_WIDTH-1:0] v0_r     [3];
    logic signed [DATA_WIDTH-1:0] origin_r [3];
    logic signed [DATA_WIDTH-1:0] dir_r    [3];
    logic signed [DATA_WIDTH-1:0] scaled   [3];
    logic [DIV_CYCLES-1:0]        quot;
    logic [DATA_WIDTH-1:0]        rem;
    logic [DATA_WIDTH-1:0]        divisor;
    logic                         res_neg;
    logic [CNT_W-1:0]             div_cnt;
    logic signed [DATA_WIDTH-1:0] t_reg;
    logic                         hit_reg;

    logic signed [DATA_WIDTH-1:0] diff [3];
    logic signed [DATA_WIDTH-1:0] num_c;
    logic signed [DATA_WIDTH-1:0] den_c;
    logic [DATA_WIDTH-1:0]        abs_num;
    logic [DATA_WIDTH-1:0]        abs_den;
    logic                         dot_miss;
    logic [DATA_WIDTH:0]          trial;
    logic                         trial_ge;
    logic signed [DATA_WIDTH-1:0] t_c;
    logic                         hit_c;

    // Full-width product rescaled to Q format, then truncated to one word
    function automatic logic signed [DATA_WIDTH-1:0] mul_q(
        input logic signed [DATA_WIDTH-1:0] a,
        input logic signed [DATA_WIDTH-1:0] b
    );
        logic signed [2*DATA_WIDTH-1:0] p;
        p = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
        p = p >>> Q_BITS;
        return p[DATA_WIDTH-1:0];
    endfunction

    assign bus.in_rd_en = reset && (state == IDLE) && !bus.in_empty;

`ifdef P_HIT_CULL_EN
    assign dot_miss = !den_c[DATA_WIDTH-1];
`else
    assign dot_miss = (den_c == '0);
`endif

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            diff[i] = v0_r[i] - origin_r[i];
        end
        num_c = mul_q(n_r[0], diff[0]) + mul_q(n_r[1], diff[1]) + mul_q(n_r[2], diff[2]);
        den_c = mul_q(n_r[0], dir_r[0]) + mul_q(n_r[1], dir_r[1]) + mul_q(n_r[2], dir_r[2]);
        abs_num = num_c[DATA_WIDTH-1] ? -num_c : num_c;
        abs_den = den_c[DATA_WIDTH-1] ? -den_c : den_c;

        trial    = {rem, quot[DIV_CYCLES-1]};
        trial_ge = (trial >= {1'b0, divisor});

        // A zero quotient is never negative, so it still counts as a hit
        t_c   = res_neg ? -quot[DATA_WIDTH-1:0] : quot[DATA_WIDTH-1:0];
        hit_c = (quot[DIV_CYCLES-1:DATA_WIDTH-1] == '0) && (!res_neg || (quot == '0));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            quot          <= '0;
            rem           <= '0;
            divisor       <= '0;
            res_neg       <= 1'b0;
            div_cnt       <= '0;
            t_reg         <= '0;
            hit_reg       <= 1'b0;
            bus.out_t     <= '0;
            bus.out_hit   <= 1'b0;
            bus.out_empty <= 1'b1;
            for (int i = 0; i < 3; i++) begin
                n_r[i]      <= '0;
                v0_r[i]     <= '0;
                origin_r[i] <= '0;
                dir_r[i]    <= '0;
                scaled[i]   <= '0;
                bus.out[i]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_rd_en) begin
                        for (int i = 0; i < 3; i++) begin
                            n_r[i]      <= bus.tri_normal[i];
                            v0_r[i]     <= bus.v0[i];
                            origin_r[i] <= bus.origin[i];
                            dir_r[i]    <= bus.dir[i];
                        end
                        state <= DOT;
                    end
                end
                DOT: begin
                    if (dot_miss) begin
                        for (int i = 0; i < 3; i++) begin
                            bus.out[i] <= '0;
                        end
                        bus.out_t   <= '0;
                        bus.out_hit <= 1'b0;
                        state       <= DONE;
                    end else begin
                        res_neg <= num_c[DATA_WIDTH-1] ^ den_c[DATA_WIDTH-1];
                        divisor <= abs_den;
                        quot    <= {abs_num, {Q_BITS{1'b0}}};
                        rem     <= '0;
                        div_cnt <= '0;
                        state   <= DIV;
                    end
                end
                DIV: begin
                    // One restoring step per cycle; dividend bits shift out as quotient bits shift in
                    quot <= {quot[DIV_CYCLES-2:0], trial_ge};
                    rem  <= trial_ge ? DATA_WIDTH'(trial - {1'b0, divisor}) : trial[DATA_WIDTH-1:0];
                    if (div_cnt == CNT_W'(DIV_CYCLES - 1)) begin
                        div_cnt <= '0;
                        state   <= SCALE;
                    end else begin
                        div_cnt <= div_cnt + CNT_W'(1);
                    end
                end
                SCALE: begin
                    t_reg   <= t_c;
                    hit_reg <= hit_c;
                    for (int i = 0; i < 3; i++) begin
                        scaled[i] <= mul_q(t_c, dir_r[i]);
                    end
                    state <= ADD;
                end
                ADD: begin
                    for (int i = 0; i < 3; i++) begin
                        bus.out[i] <= origin_r[i] + scaled[i];
                    end
                    bus.out_t     <= t_reg;
                    bus.out_hit   <= hit_reg;
                    bus.out_empty <= 1'b0;
                    state         <= DONE;
                end
                DONE: begin
                    // A miss from DOT arrives still empty and is presented one cycle later
                    if (bus.out_empty) begin
                        bus.out_empty <= 1'b0;
                    end else if (bus.out_rd_en) begin
                        bus.out_empty <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_p_hit_pipe.sv
// Randomized bench for p_hit_pipe against an arithmetic reference model,
// plus directed reset, miss-path, back-pressure and spurious-pop cases.
module tb_p_hit_pipe;
    localparam int DW = 32;
    localparam int QB = 16;

    typedef struct packed {
        logic [2:0][31:0] n, v, o, d;
    } ray_t;

    typedef struct packed {
        logic [2:0][31:0] p;
        logic [31:0]      t;
        logic             hit;
        logic             miss;
    } res_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   check_count = 0;
    int   error_count = 0;

    always #5 clock = ~clock;

    p_hit_pipe_if #(.DATA_WIDTH(DW)) bus ();

    p_hit_pipe #(
        .DATA_WIDTH(DW),
        .Q_BITS    (QB)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input ray_t r);
        for (int i = 0; i < 3; i++) begin
            bus.tri_normal[i] = r.n[i];
            bus.v0[i]         = r.v[i];
            bus.origin[i]     = r.o[i];
            bus.dir[i]        = r.d[i];
        end
        bus.in_empty = 1'b0;
    endtask

    // Straight arithmetic on 64-bit integers: dot products, signed division, scale and add
    function automatic res_t refModel(input ray_t r);
        longint num, den, q;
        int     diff, t;
        res_t   res;
        num = 0;
        den = 0;
        for (int i = 0; i < 3; i++) begin
            diff = $signed(r.v[i]) - $signed(r.o[i]);
            num += (longint'($signed(r.n[i])) * longint'(diff)) >>> QB;
            den += (longint'($signed(r.n[i])) * longint'($signed(r.d[i]))) >>> QB;
        end
        num = longint'(int'(num));
        den = longint'(int'(den));
        res = '0;
`ifdef P_HIT_CULL_EN
        res.miss = (den >= 0);
`else
        res.miss = (den == 0);
`endif
        if (!res.miss) begin
            q       = (num * 65536) / den;
            t       = int'(q);
            res.t   = t;
            res.hit = (q >= 0) && (q <= 64'sd2147483647);
            for (int i = 0; i < 3; i++) begin
                res.p[i] = int'(longint'($signed(r.o[i])) + ((longint'(t) * longint'($signed(r.d[i]))) >>> QB));
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] rndQ();
        int x;
        x = int'($urandom_range(0, 1048575)) - 524288;
        return x;
    endfunction

    function automatic ray_t randRay();
        ray_t r;
        for (int i = 0; i < 3; i++) begin
            r.n[i] = rndQ();
            r.v[i] = rndQ();
            r.o[i] = rndQ();
            r.d[i] = rndQ();
        end
        if ($urandom_range(0, 4) == 0) begin
            r.n[1] = '0;
            r.n[2] = '0;
            r.d[0] = '0;
        end
        return r;
    endfunction

    task automatic checkResult(input string tag, input res_t e);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("%s/out%0d", tag, i), bus.out[i], e.p[i]);
        end
        checkOutput({tag, "/out_t"}, bus.out_t, e.t);
        checkOutput({tag, "/out_hit"}, 32'(bus.out_hit), 32'(e.hit));
    endtask

    // Entered between edges with the pipeline idle; leaves it idle again
    task automatic runRay(input string tag, input ray_t r, input res_t e);
        int lat;
        applyStimulus(r);
        #1;
        checkOutput({tag, "/in_rd_en"}, 32'(bus.in_rd_en), 32'd1);
        @(posedge clock);
        #1;
        bus.in_empty = 1'b1;
        lat = 0;
        while (bus.out_empty && lat < 200) begin
            @(posedge clock);
            #1;
            lat++;
        end
        checkOutput({tag, "/latency"}, lat, e.miss ? 32'd2 : 32'(DW + QB + 3));
        checkResult(tag, e);
        bus.out_rd_en = 1'b1;
        @(posedge clock);
        #1;
        bus.out_rd_en = 1'b0;
        checkOutput({tag, "/popped"}, 32'(bus.out_empty), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        ray_t   r, base, r1, r2;
        res_t   e;
        res_t   q_exp[$];
        ray_t   q_in[$];
        int     accepts[$];
        int     pops[$];
        int     cyc;
        logic   seen, took;

        base = '0;
        base.n[2] = 32'h00010000;
        base.v[2] = 32'hFFFB0000;
        base.d[2] = 32'hFFFF0000;
        applyStimulus(base);
        bus.in_empty  = 1'b1;
        bus.out_rd_en = 1'b0;

        #3 reset = 1'b0;
        bus.in_empty = 1'b0;
        #1;
        checkOutput("reset/in_rd_en", 32'(bus.in_rd_en), 32'd0);
        checkOutput("reset/out_empty", 32'(bus.out_empty), 32'd1);
        checkOutput("reset/out_hit", 32'(bus.out_hit), 32'd0);
        checkOutput("reset/out_t", bus.out_t, 32'd0);
        checkOutput("reset/out2", bus.out[2], 32'd0);
        bus.in_empty = 1'b1;
        repeat (3) @(posedge clock);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;

        e = '0;
        e.p[2] = 32'hFFFB0000;
        e.t    = 32'h00050000;
        e.hit  = 1'b1;
        runRay("front_hit", base, e);

        r = base;
        r.d[2] = '0;
        r.d[0] = 32'h00010000;
        e = '0;
        e.miss = 1'b1;
        runRay("parallel", r, e);

        r = base;
        r.v[2] = 32'h00050000;
`ifndef P_HIT_CULL_EN
        e = '0;
        e.p[2] = 32'h00050000;
        e.t    = 32'hFFFB0000;
        runRay("behind", r, e);
`endif
        r.d[2] = 32'h00010000;
        runRay("back_face", r, refModel(r));

        applyStimulus(base);
        @(posedge clock);
        #1;
        bus.in_empty = 1'b1;
        repeat (10) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        checkOutput("mid_reset/out_empty", 32'(bus.out_empty), 32'd1);
        checkOutput("mid_reset/out_t", bus.out_t, 32'd0);
        #2 reset = 1'b1;
        seen = 1'b0;
        repeat (60) begin
            @(posedge clock);
            #1;
            if (!bus.out_empty) seen = 1'b1;
        end
        checkOutput("mid_reset/stays_empty", 32'(seen), 32'd0);

        for (int k = 0; k < 20; k++) begin
            r = randRay();
            runRay($sformatf("rand%0d", k), r, refModel(r));
        end

        r1 = randRay();
        r2 = randRay();
        q_in  = '{r1, r2};
        q_exp = '{refModel(r1), refModel(r2)};
        bus.out_rd_en = 1'b1;
        applyStimulus(q_in[0]);
        #1;
        cyc = 0;
        while (pops.size() < 2 && cyc < 400) begin
            took = bus.in_rd_en;
            if (took) accepts.push_back(cyc);
            if (!bus.out_empty) begin
                pops.push_back(cyc);
                checkResult($sformatf("queued%0d", pops.size()), q_exp.pop_front());
            end
            @(posedge clock);
            #1;
            cyc++;
            if (took) begin
                void'(q_in.pop_front());
                if (q_in.size() > 0) applyStimulus(q_in[0]);
                else bus.in_empty = 1'b1;
            end
        end
        bus.out_rd_en = 1'b0;
        bus.in_empty  = 1'b1;
        checkOutput("queued/pops", pops.size(), 32'd2);
        checkOutput("queued/accepts", accepts.size(), 32'd2);
        if (accepts.size() >= 2 && pops.size() >= 1) begin
            checkOutput("queued/second_accept", accepts[1], pops[0] + 1);
        end
        repeat (2) @(posedge clock);
        #1;

        seen = 1'b0;
        bus.out_rd_en = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (bus.in_rd_en || !bus.out_empty) seen = 1'b1;
            @(posedge clock);
            #1;
            if (bus.in_rd_en || !bus.out_empty) seen = 1'b1;
        end
        bus.out_rd_en = 1'b0;
        checkOutput("spurious_pop/no_glitch", 32'(seen), 32'd0);
        e = '0;
        e.p[2] = 32'hFFFB0000;
        e.t    = 32'h00050000;
        e.hit  = 1'b1;
        runRay("after_spurious", base, e);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end
endmodule
